axi4_lite_write_arbiter: RTL

- Two-requester AXI4-Lite write master that shares a single AXI4-Lite write slave (the AXI4_write block) between two internal clients, e.g. the core store path and a debug/DMA port.
- Arbitrates round-robin, latches the winner's address and data, and drives the AW and W channels independently.
- Collects the B response and returns it to the granted requester as a one-cycle done pulse.
- Only one transaction is in flight at a time.

---
 rtl/axi4_lite_pkg.sv | 13 +
 rtl/rr_arbiter_2.sv | 15 +
 rtl/axi4_lite_write_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/axi4_lite_pkg.sv
// Shared state encoding and AXI response codes for the AXI4-Lite write arbiter.
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin pick: favours the requester that did not win last time.
module rr_arbiter_2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  always_comb begin
    gnt_valid = |req;
    gnt_idx   = ~last_grant;
    if (!req[~last_grant]) gnt_idx = last_grant;
  end

endmodule

// File: rtl/axi4_lite_write_arbiter.sv
// Shares one AXI4-Lite write slave between two requesters, one transaction in flight.
// state | meaning
// IDLE  | nothing in flight; arbitrate, latch winner's addr/data
// SEND  | AW and W valids up, each dropping on its own handshake
// RESP  | B ready up, waiting for the slave's response
module axi4_lite_write_arbiter
  import axi4_lite_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 2,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     axi_clk,
  input  logic                     resetn,
  input  logic                     req0_valid,
  input  logic [ADDRESS_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0]    req0_data,
  output logic                     req0_ready,
  output logic                     req0_done,
  output logic [1:0]               req0_resp,
  input  logic                     req1_valid,
  input  logic [ADDRESS_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0]    req1_data,
  output logic                     req1_ready,
  output logic                     req1_done,
  output logic [1:0]               req1_resp,
  output logic [ADDRESS_WIDTH-1:0] write_addr,
  output logic                     write_addr_valid,
  input  logic                     write_addr_ready,
  output logic [DATA_WIDTH-1:0]    write_data,
  output logic                     write_data_valid,
  input  logic                     write_data_ready,
  input  logic [1:0]               write_resp,
  input  logic                     write_resp_valid,
  output logic                     write_resp_ready,
  output logic                     busy,
  output logic                     grant
);

  state_t state, state_nxt;
  logic   last_grant;
  logic   aw_pend, w_pend, aw_pend_nxt, w_pend_nxt;
  logic   gnt_valid, gnt_idx, accept;

  rr_arbiter_2 u_arb (
    .req        ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx)
  );

  assign accept      = (state == IDLE) && gnt_valid;
  assign req0_ready  = accept && !gnt_idx;
  assign req1_ready  = accept && gnt_idx;
  assign aw_pend_nxt = aw_pend && !write_addr_ready;
  assign w_pend_nxt  = w_pend && !write_data_ready;

  assign write_addr_valid = aw_pend;
  assign write_data_valid = w_pend;
  assign write_resp_ready = (state == RESP);
  assign busy             = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_valid) state_nxt = SEND;
      SEND:    if (!aw_pend_nxt && !w_pend_nxt) state_nxt = RESP;
      RESP:    if (write_resp_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge axi_clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge axi_clk or negedge resetn) begin
    if (!resetn) begin
      last_grant <= 1'b1;
      grant      <= 1'b0;
      aw_pend    <= 1'b0;
      w_pend     <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
      req0_done  <= 1'b0;
      req1_done  <= 1'b0;
      req0_resp  <= RESP_OKAY;
      req1_resp  <= RESP_OKAY;
    end else begin
      req0_done <= 1'b0;
      req1_done <= 1'b0;
      case (state)
        IDLE: if (gnt_valid) begin
          grant      <= gnt_idx;
          write_addr <= gnt_idx ? req1_addr : req0_addr;
          write_data <= gnt_idx ? req1_data : req0_data;
          aw_pend    <= 1'b1;
          w_pend     <= 1'b1;
        end
        SEND: begin
          aw_pend <= aw_pend_nxt;
          w_pend  <= w_pend_nxt;
        end
        RESP: if (write_resp_valid) begin
          last_grant <= grant;
          if (grant) begin
            req1_done <= 1'b1;
            req1_resp <= write_resp;
          end else begin
            req0_done <= 1'b1;
            req0_resp <= write_resp;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
